// File: rtl/app_chain_sched.sv
// Walks one lookup through a chain of stateful apps on a shared request bus, following next_app
// until it is zero. The hop count and per-hop wait are both bounded, so a looping or hung app cannot stall it.
module app_chain_sched #(
   parameter int ENTRY_W  = 32,
   parameter int ACTION_W = 16,
   parameter int EVP_W    = 24,
   parameter int NUM_APPS = 3,
   parameter int MAX_HOPS = 4,
   parameter int TIMEOUT  = 255
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_vld,
   output logic                         in_rdy,
   input  logic [ENTRY_W-1:0]           in_match,
   input  logic [ACTION_W-1:0]          in_action,
   input  logic [EVP_W-1:0]             in_evp,
   input  logic [1:0]                   in_app_id,
   output logic                         app_match_vld,
   output logic [1:0]                   app_id,
   output logic [ENTRY_W-1:0]           app_match,
   output logic [ACTION_W-1:0]          app_action,
   output logic [EVP_W-1:0]             app_evp,
   input  logic [NUM_APPS-1:0]          app_done,
   input  logic [NUM_APPS*ACTION_W-1:0] app_action_out,
   input  logic [NUM_APPS*EVP_W-1:0]    app_evp_out,
   input  logic [NUM_APPS*2-1:0]        app_next,
   output logic                         out_vld,
   input  logic                         out_rdy,
   output logic [ENTRY_W-1:0]           out_match,
   output logic [ACTION_W-1:0]          out_action,
   output logic [EVP_W-1:0]             out_evp,
   output logic [1:0]                   out_err,
   output logic [3:0]                   out_hops,
   output logic [15:0]                  stray_cnt
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_HOPS    = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;

   localparam logic [3:0] MAX_HOPS_C   = 4'(MAX_HOPS);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   logic [1:0]          state;
   logic [1:0]          next_state;
   logic [1:0]          cur_id;
   logic [3:0]          hops;
   logic [7:0]          timer;
   logic [ENTRY_W-1:0]  lat_match;
   logic [ACTION_W-1:0] lat_action;
   logic [EVP_W-1:0]    lat_evp;

   logic [NUM_APPS-1:0] cur_mask;
   logic [ACTION_W-1:0] sel_action;
   logic [EVP_W-1:0]    sel_evp;
   logic [1:0]          sel_next;
   logic                cur_done;
   logic                accept;
   logic                id_ok;
   logic                next_ok;
   logic                chain_more;
   logic                idle_issue;
   logic                idle_skip;
   logic                wait_issue;
   logic                wait_end;
   logic                wait_tmo;
   logic                stray;

   // Pick out the result lanes of the app currently being waited on
   always_comb begin
      cur_mask   = '0;
      sel_action = '0;
      sel_evp    = '0;
      sel_next   = '0;
      for (int i = 0; i < NUM_APPS; i++) begin
         if (cur_id == 2'(i + 1)) begin
            cur_mask[i] = 1'b1;
            sel_action  = app_action_out[i*ACTION_W +: ACTION_W];
            sel_evp     = app_evp_out[i*EVP_W +: EVP_W];
            sel_next    = app_next[i*2 +: 2];
         end
      end
   end

   assign cur_done = |(app_done & cur_mask);
   assign accept   = in_vld && in_rdy;
   assign id_ok    = (in_app_id != 2'd0) && (int'(in_app_id) <= NUM_APPS);
   // A next_app that names no existing app ends the chain just like 0
   assign next_ok    = (sel_next != 2'd0) && (int'(sel_next) <= NUM_APPS);
   assign chain_more = next_ok && (hops < MAX_HOPS_C);

   assign idle_issue = (state == IDLE) && accept && id_ok;
   assign idle_skip  = (state == IDLE) && accept && !id_ok;
   assign wait_issue = (state == WAIT) && cur_done && chain_more;
   assign wait_end   = (state == WAIT) && cur_done && !chain_more;
   assign wait_tmo   = (state == WAIT) && !cur_done && (timer == TIMEOUT_LAST);

   assign stray = (state == WAIT) ? |(app_done & ~cur_mask) : |app_done;

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (idle_issue) next_state = ISSUE;
                  else if (idle_skip) next_state = DONE;
         ISSUE:   next_state = WAIT;
         WAIT:    if (wait_issue) next_state = ISSUE;
                  else if (wait_end || wait_tmo) next_state = DONE;
         DONE:    if (out_rdy) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // in_rdy is registered so it stays low through reset and the handoff cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         in_rdy <= 1'b0;
      end else begin
         state  <= next_state;
         in_rdy <= (next_state == IDLE);
      end
   end

   // Per-lookup bookkeeping; lat_action/lat_evp always hold what the current hop was given
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_id     <= '0;
         hops       <= '0;
         timer      <= '0;
         lat_match  <= '0;
         lat_action <= '0;
         lat_evp    <= '0;
      end else begin
         if (state == IDLE && accept) begin
            cur_id     <= in_app_id;
            hops       <= '0;
            lat_match  <= in_match;
            lat_action <= in_action;
            lat_evp    <= in_evp;
         end
         if (state == ISSUE) begin
            hops  <= hops + 4'd1;
            timer <= '0;
         end
         if (state == WAIT) begin
            timer <= timer + 8'd1;
         end
         if (state == WAIT && cur_done) begin
            lat_action <= sel_action;
            lat_evp    <= sel_evp;
         end
         if (wait_issue) begin
            cur_id <= sel_next;
         end
      end
   end

   // Request bus: one-cycle pulse, payload held until the following issue
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         app_match_vld <= 1'b0;
         app_id        <= '0;
         app_match     <= '0;
         app_action    <= '0;
         app_evp       <= '0;
      end else begin
         app_match_vld <= idle_issue || wait_issue;
         if (idle_issue) begin
            app_id     <= in_app_id;
            app_match  <= in_match;
            app_action <= in_action;
            app_evp    <= in_evp;
         end else if (wait_issue) begin
            app_id     <= sel_next;
            app_match  <= lat_match;
            app_action <= sel_action;
            app_evp    <= sel_evp;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_vld    <= 1'b0;
         out_match  <= '0;
         out_action <= '0;
         out_evp    <= '0;
         out_err    <= '0;
         out_hops   <= '0;
      end else if (idle_skip) begin
         out_vld    <= 1'b1;
         out_match  <= in_match;
         out_action <= in_action;
         out_evp    <= in_evp;
         out_err    <= ERR_OK;
         out_hops   <= '0;
      end else if (wait_end) begin
         out_vld    <= 1'b1;
         out_match  <= lat_match;
         out_action <= sel_action;
         out_evp    <= sel_evp;
         out_err    <= next_ok ? ERR_HOPS : ERR_OK;
         out_hops   <= hops;
      end else if (wait_tmo) begin
         out_vld    <= 1'b1;
         out_match  <= lat_match;
         out_action <= lat_action;
         out_evp    <= lat_evp;
         out_err    <= ERR_TIMEOUT;
         out_hops   <= hops;
      end else if (state == DONE && out_rdy) begin
         out_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stray_cnt <= '0;
      end else if (stray && (stray_cnt != 16'hFFFF)) begin
         stray_cnt <= stray_cnt + 16'd1;
      end
   end

endmodule
